sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Clocked, synthesizable responder for the 16-bit external SRAM pin interface (`SRAM_ADDR`/`SRAM_DQ`/`*_N` strobes) driven by the memory controller.
- Serves as the on-chip SRAM stand-in for simulation and FPGA builds without the physical chip.
- Stores 16-bit words with byte-lane masking and returns read data over the shared bidirectional bus after a fixed pipeline latency.
- Reports access counts, bus contention and out-of-range accesses for debug.

Parameters:
- `ADDR_W`, 18, width of `SRAM_ADDR`.
- `DEPTH`, 65536, implemented words; legal addresses are 0..DEPTH-1 (DEPTH <= 2**ADDR_W).
- `RD_LAT`, 1, read latency in clocks from accepted read to data on bus; legal range 1..4.
- `CNT_W`, 32, width of access counters.

Ports:
- `clk`  in  1  clock; all sampling on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `SRAM_ADDR`  in  ADDR_W  word address.
- `SRAM_DQ`  inout  16  bidirectional data; [15:8] upper byte, [7:0] lower byte.
- `SRAM_UB_N`  in  1  upper-byte enable, active-low.
- `SRAM_LB_N`  in  1  lower-byte enable, active-low.
- `SRAM_WE_N`  in  1  write enable, active-low.
- `SRAM_CE_N`  in  1  chip enable, active-low.
- `SRAM_OE_N`  in  1  output enable, active-low.
- `rd_count`  out  CNT_W  accepted reads since reset.
- `wr_count`  out  CNT_W  accepted writes since reset.
- `contention`  out  1  sticky: read data was due while a write was on the bus.
- `oob_err`  out  1  sticky: access to address >= DEPTH.

Behaviour:
- Reset:
  - `rd_count`=0, `wr_count`=0, `contention`=0, `oob_err`=0.
  - Read pipeline valid bits cleared; `SRAM_DQ` Z.
  - Memory array contents not reset; they persist across `rst`.
  - Reset mid-read discards the in-flight read, and `SRAM_DQ` releases to Z immediately (asynchronous).
- Write accept, at posedge with `CE_N`=0 and `WE_N`=0 (`OE_N` ignored):
  - `mem[ADDR][15:8]` <= `DQ[15:8]` if `UB_N`=0.
  - `mem[ADDR][7:0]` <= `DQ[7:0]` if `LB_N`=0.
  - `wr_count`++ (wraps), even when both lanes are masked.
- Read accept, at posedge with `CE_N`=0, `WE_N`=1, `OE_N`=0:
  - Push {valid=1, data=mem[ADDR], ub_n, lb_n} into an RD_LAT-deep shift pipeline.
  - `rd_count`++ (wraps).
  - Back-to-back reads accepted every cycle; throughput is 1 per clock.
- Idle cycles (`CE_N`=1, or `WE_N`=1 with `OE_N`=1) push valid=0.
- Read latency: data of a read accepted at edge N is driven from just after edge N+RD_LAT-1 until edge N+RD_LAT. With RD_LAT=1 the word is valid for the whole cycle following the accepting edge.
- Bus drive: lane [15:8] is driven only when all of these hold, otherwise Z:
  - pipeline head valid;
  - head ub_n=0;
  - current `CE_N`=0, `OE_N`=0, `WE_N`=1.
  - Lane [7:0] follows the same rule with lb_n.
- Drive gating is combinational on the current strobes, so deasserting `OE_N` or `CE_N` releases the bus in the same cycle.
- Read/write hazard: a read of an address written at an earlier edge returns the new data. A read accepted at the same edge as a write cannot occur (`WE_N` is exclusive).
- Contention: if the pipeline head is valid while current `CE_N`=0 and `WE_N`=0:
  - Responder does not drive.
  - `contention` <= 1 at the next edge.
  - The write still proceeds.
- Out of range (ADDR >= DEPTH):
  - Write is ignored but counted.
  - Read returns 16'h0000 and is counted.
  - `oob_err` <= 1 at that edge.
- Sticky flags clear only on `rst`.
- Counter wrap: all-ones + 1 -> 0, with no flag.
- Simulation-only assertion: X/Z on `SRAM_DQ` lanes being written.

Test Plan:
- Write 16'hBEEF to addr 5 (UB_N=LB_N=0), then read addr 5 with RD_LAT=1 -> `SRAM_DQ`=16'hBEEF in the cycle after the read edge; `wr_count`=1, `rd_count`=1.
- Byte masking: mem[9]=16'h1234; write 16'hAB00 with UB_N=0, LB_N=1 -> mem[9]=16'hAB34. A read with LB_N=1 drives [15:8]=8'hAB and leaves [7:0] Z.
- Burst: RD_LAT=3, write 4 words 0x1111..0x4444 to addrs 0..3, then 4 consecutive reads -> data appears on edges 3..6 after the first read, in order, with no gaps.
- Contention and OE gating:
  - RD_LAT=2, read addr 0 then assert WE_N=0 on the next edge -> no drive, `contention`=1, write applied.
  - Separately, OE_N=1 during the data cycle -> DQ=Z.
- Out of range: DEPTH=1024, read addr 1024 -> DQ=16'h0000, `oob_err`=1; write to 2000 leaves mem unchanged.
- Reset mid-read: RD_LAT=4, assert rst 2 cycles after the read -> DQ Z immediately, counters 0, flags 0, and mem[5] still 16'hBEEF afterwards.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for a 16-bit async SRAM on the controller's pin bus.
// Latency: read data is driven on SRAM_DQ for one clock, RD_LAT clocks after the accepting edge.
// Backpressure: none; one access per clock, and the bus is released as soon as the read strobes drop.
module sram_responder #(
    parameter int ADDR_W = 18,
    parameter int DEPTH  = 65536,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              contention,
    output logic              oob_err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // One read in flight: the lane enables captured at accept time plus the word.
    typedef struct packed {
        logic        ub_n;
        logic        lb_n;
        logic [15:0] dat;
    } rd_slot_t;

    logic [15:0]           mem [DEPTH];
    logic [RD_LAT-1:0]     pipe_vld;
    rd_slot_t [RD_LAT-1:0] pipe_slot;

    logic             rd_acc;
    logic             wr_acc;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             head_vld;
    rd_slot_t         head;
    logic             drv_hi;
    logic             drv_lo;

    assign rd_acc   = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
    assign wr_acc   = !SRAM_CE_N && !SRAM_WE_N;
    assign in_range = {1'b0, SRAM_ADDR} < DEPTH_L;
    assign idx      = SRAM_ADDR[IDX_W-1:0];
    assign head_vld = pipe_vld[RD_LAT-1];
    assign head     = pipe_slot[RD_LAT-1];

    // Drive gating uses the live strobes, so a write on the bus (contention)
    // or a dropped OE_N/CE_N keeps the responder off the wires this cycle.
    assign drv_hi = head_vld && !head.ub_n && rd_acc;
    assign drv_lo = head_vld && !head.lb_n && rd_acc;

    assign SRAM_DQ[15:8] = drv_hi ? head.dat[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = drv_lo ? head.dat[7:0]  : 8'hzz;

    // Array writes with lane masks, and the data half of the read pipeline.
    // Neither is reset: memory must survive rst, and slots are qualified by pipe_vld.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
            if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
        end
        pipe_slot[0] <= '{ub_n: SRAM_UB_N, lb_n: SRAM_LB_N,
                          dat:  in_range ? mem[idx] : 16'h0000};
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_slot[i] <= pipe_slot[i-1];
        end
    end

    // Valid bits, access counters and sticky debug flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld   <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
            contention <= 1'b0;
            oob_err    <= 1'b0;
        end else begin
            pipe_vld[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
            if (rd_acc) rd_count <= rd_count + CNT_W'(1);
            if (wr_acc) wr_count <= wr_count + CNT_W'(1);
            if ((rd_acc || wr_acc) && !in_range) oob_err <= 1'b1;
            if (head_vld && wr_acc) contention <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Catch the controller writing undriven or unknown data into an enabled lane.
    always @(posedge clk) begin
        if (!rst && wr_acc) begin
            assert (SRAM_UB_N || !$isunknown(SRAM_DQ[15:8]));
            assert (SRAM_LB_N || !$isunknown(SRAM_DQ[7:0]));
        end
    end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized and directed traffic against a queue/array reference model.
// Stimulus pushes expected read words with their due cycle; a negedge monitor pops and compares.
// Undriven bus lanes resolve through pullups, so a released lane reads as 8'hFF.
module tb_sram_responder;

    localparam int ADDR_W = 18;
    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 3;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic              ub_n = 1'b1;
    logic              lb_n = 1'b1;
    logic              we_n = 1'b1;
    logic              ce_n = 1'b1;
    logic              oe_n = 1'b1;
    logic [15:0]       tb_dq = 16'h0000;
    logic              tb_dq_en = 1'b0;
    wire  [15:0]       dq;
    wire  [CNT_W-1:0]  rd_count;
    wire  [CNT_W-1:0]  wr_count;
    wire               contention;
    wire               oob_err;

    assign dq = tb_dq_en ? tb_dq : 16'hzzzz;

    for (genvar g = 0; g < 16; g++) begin : g_pull
        pullup (dq[g]);
    end

    sram_responder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SRAM_ADDR  (addr),
        .SRAM_DQ    (dq),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n),
        .SRAM_WE_N  (we_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_OE_N  (oe_n),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .contention (contention),
        .oob_err    (oob_err)
    );

    always #5 clk = ~clk;

    // Reference model state.
    typedef struct {
        int          due;
        logic [15:0] d;
        logic        ub_n;
        logic        lb_n;
    } rd_exp_t;

    logic [15:0] ref_mem [int];
    rd_exp_t     rq [$];
    int          cyc       = 0;
    int          exp_rd    = 0;
    int          exp_wr    = 0;
    bit          exp_oob   = 1'b0;
    bit          exp_cont  = 1'b0;
    bit          cont_pend = 1'b0;
    int          n_tests   = 0;
    int          n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        exp_rd    = 0;
        exp_wr    = 0;
        exp_oob   = 1'b0;
        exp_cont  = 1'b0;
        cont_pend = 1'b0;
    endtask

    // Apply one cycle of strobes, wait for the edge, then update the model for that edge.
    task automatic cyc_op(input logic c, input logic w, input logic o, input logic u,
                          input logic l, input int a, input logic [15:0] d);
        rd_exp_t e;
        ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l;
        addr = a[ADDR_W-1:0];
        tb_dq = d;
        tb_dq_en = !w;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            if (cont_pend) exp_cont = 1'b1;
            if (!c && !w) begin
                exp_wr++;
                if (a >= DEPTH) exp_oob = 1'b1;
                else begin
                    if (!u) ref_mem[a][15:8] = d[15:8];
                    if (!l) ref_mem[a][7:0]  = d[7:0];
                end
            end else if (!c && !o) begin
                exp_rd++;
                if (a >= DEPTH) exp_oob = 1'b1;
                e.due  = cyc + RD_LAT - 1;
                e.d    = (a >= DEPTH) ? 16'h0000 : ref_mem[a];
                e.ub_n = u;
                e.lb_n = l;
                rq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 16'h0);
    endtask

    task automatic wr(input int a, input logic [15:0] d, input logic u, input logic l);
        cyc_op(1'b0, 1'b0, 1'b1, u, l, a, d);
    endtask

    task automatic rd(input int a, input logic u, input logic l);
        cyc_op(1'b0, 1'b1, 1'b0, u, l, a, 16'h0);
    endtask

    // n back-to-back reads of one address, then drain the pipeline.
    task automatic rd_n(input int a, input logic u, input logic l, input int n);
        for (int i = 0; i < n; i++) rd(a, u, l);
        idle(RD_LAT);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        model_reset();
        idle(hold);
        rst = 1'b0;
    endtask

    // Monitor: every mid-cycle, pop the read due now and compare bus, counters and flags.
    initial begin
        rd_exp_t     h;
        bit          hv;
        logic [15:0] exp_dq;
        forever begin
            @(negedge clk);
            hv = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                h  = rq.pop_front();
                hv = 1'b1;
            end
            if (tb_dq_en) exp_dq = tb_dq;
            else begin
                exp_dq = 16'hFFFF;
                if (!rst && hv && !ce_n && !oe_n && we_n) begin
                    if (!h.ub_n) exp_dq[15:8] = h.d[15:8];
                    if (!h.lb_n) exp_dq[7:0]  = h.d[7:0];
                end
            end
            check("dq", 32'(dq), 32'(exp_dq));
            check("rd_count", 32'(rd_count), 32'(exp_rd[CNT_W-1:0]));
            check("wr_count", 32'(wr_count), 32'(exp_wr[CNT_W-1:0]));
            check("contention", 32'(contention), 32'(exp_cont));
            check("oob_err", 32'(oob_err), 32'(exp_oob));
            cont_pend = !rst && hv && !ce_n && !we_n;
        end
    end

    initial begin
        int op;
        int r;
        int a;
        do_reset(3);

        // Give every address the random traffic may read a known value.
        for (int i = 0; i < 16; i++) wr(i, 16'($urandom), 1'b0, 1'b0);
        wr(976, 16'h0F0F, 1'b0, 1'b0);

        // Full-word write then read back.
        wr(5, 16'hBEEF, 1'b0, 1'b0);
        rd_n(5, 1'b0, 1'b0, RD_LAT + 1);

        // Upper-lane-only write and upper-lane-only read.
        wr(9, 16'h1234, 1'b0, 1'b0);
        wr(9, 16'hAB00, 1'b0, 1'b1);
        rd_n(9, 1'b0, 1'b1, RD_LAT + 1);
        rd_n(9, 1'b0, 1'b0, RD_LAT + 1);

        // Burst of four reads, strobes held for the data cycles.
        for (int i = 0; i < 4; i++) wr(i, 16'(16'h1111 * (i + 1)), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd(i, 1'b0, 1'b0);
        rd_n(0, 1'b0, 1'b0, RD_LAT);

        // OE_N high while data is due: bus must stay released.
        rd(5, 1'b0, 1'b0);
        for (int i = 0; i < RD_LAT; i++) cyc_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5, 16'h0);
        idle(1);

        // Out-of-range read returns zero; out-of-range write must not alias.
        rd_n(1024, 1'b0, 1'b0, RD_LAT + 1);
        wr(2000, 16'h5A5A, 1'b0, 1'b0);
        rd_n(976, 1'b0, 1'b0, RD_LAT + 1);

        // Reset while read data is on the bus: immediate release, counters cleared.
        for (int i = 0; i < RD_LAT; i++) rd(5, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_dq_release", 32'(dq), 32'h0000FFFF);
        check("rst_rd_count", 32'(rd_count), 32'h0);
        check("rst_wr_count", 32'(wr_count), 32'h0);
        check("rst_oob", 32'(oob_err), 32'h0);
        idle(2);
        rst = 1'b0;
        rd_n(5, 1'b0, 1'b0, RD_LAT + 1);

        // Write arriving while read data is due: contention, and the write still lands.
        rd(0, 1'b0, 1'b0);
        idle(RD_LAT - 1);
        wr(0, 16'hC0DE, 1'b0, 1'b0);
        idle(1);
        rd_n(0, 1'b0, 1'b0, RD_LAT + 1);

        // Random traffic from a clean reset; enough reads and writes to wrap the counters.
        do_reset(2);
        for (int n = 0; n < 1500; n++) begin
            op = $urandom_range(0, 5);
            r  = $urandom_range(0, 19);
            if (r < 16)       a = r;
            else if (r == 16) a = 976;
            else if (r == 17) a = 1024 + $urandom_range(0, 1023);
            else if (r == 18) a = 2000;
            else              a = (1 << ADDR_W) - 1;
            case (op)
                0:       idle(1);
                1:       cyc_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, 16'h0);
                2, 3:    rd(a, 1'($urandom), 1'($urandom));
                4:       wr(a, 16'($urandom), 1'b0, 1'b0);
                default: wr(a, 16'($urandom), 1'($urandom), 1'($urandom));
            endcase
        end
        idle(RD_LAT + 2);
        check("reads_drained", 32'(rq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
